// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: data width, special instruction encodings
// and the fetch FSM state encoding.
package mips_pkg;

  localparam int          NB_DATA    = 32;
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } fetch_state_t;

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction memory: synchronous write port for the debug
// loader, combinational read port for fetch. Contents survive reset.
module instruction_memory #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
) (
  input  logic               clk,
  input  logic               we,
  input  logic [NB_ADDR-1:0] waddr,
  input  logic [NB_DATA-1:0] wdata,
  input  logic [NB_ADDR-1:0] raddr,
  output logic [NB_DATA-1:0] rdata
);

  logic [NB_DATA-1:0] mem [2**NB_ADDR];

  // Loader write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: program counter, fetch FSM (IDLE/RUN/HALT) and the IF/ID register
// feeding instruction_decode, with stall, redirect and single-step control.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter int                 NB_DATA    = mips_pkg::NB_DATA,
  parameter int                 NB_ADDR    = 8,
  parameter logic [NB_DATA-1:0] HALT_INSTR = mips_pkg::HALT_INSTR
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_load_we,
  input  logic [NB_ADDR-1:0] i_load_addr,
  input  logic [NB_DATA-1:0] i_load_data,
  input  logic               i_start,
  input  logic               i_step_mode,
  input  logic               i_step,
  input  logic               i_stall,
  input  logic               i_jump,
  input  logic [NB_DATA-1:0] i_addr2jump,
  output logic [NB_DATA-1:0] o_instruction,
  output logic [NB_DATA-1:0] o_pcounter4,
  output logic [NB_DATA-1:0] o_pc,
  output logic               o_halt,
  output logic               o_running
);

  localparam logic [NB_DATA-1:0] NOP = NB_DATA'(NOP_INSTR);

  fetch_state_t       state;
  fetch_state_t       next_state;
  logic               advance;
  logic               flush;
  logic               load_en;
  logic [NB_DATA-1:0] pc;
  logic [NB_DATA-1:0] pc_plus4;
  logic [NB_DATA-1:0] mem_word;
  logic [NB_DATA-1:0] instr;
  logic [NB_DATA-1:0] pcounter4;
  logic               running;
  logic               halted;

  instruction_memory #(
    .NB_DATA(NB_DATA),
    .NB_ADDR(NB_ADDR)
  ) u_imem (
    .clk  (clk),
    .we   (load_en),
    .waddr(i_load_addr),
    .wdata(i_load_data),
    .raddr(pc[NB_ADDR+1:2]),
    .rdata(mem_word)
  );

  assign pc_plus4 = pc + NB_DATA'(3'd4);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next state; a halt word fetched together with a redirect is flushed, not obeyed.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (i_start) next_state = ST_RUN;
        else         next_state = ST_IDLE;
      end
      ST_RUN: begin
        if (advance && !i_jump && (mem_word == HALT_INSTR)) next_state = ST_HALT;
        else                                                 next_state = ST_RUN;
      end
      ST_HALT: next_state = ST_HALT;
      default: next_state = ST_IDLE;
    endcase
  end

  // FSM outputs: loader enable, pipeline advance and post-halt flush.
  always_comb begin
    advance = 1'b0;
    flush   = 1'b0;
    load_en = 1'b0;
    case (state)
      ST_IDLE: load_en = i_load_we;
      ST_RUN:  advance = !i_stall && (!i_step_mode || i_step);
      ST_HALT: flush   = 1'b1;
      default: begin
        advance = 1'b0;
        flush   = 1'b0;
        load_en = 1'b0;
      end
    endcase
  end

  // PC, IF/ID register and registered status flags.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      pc        <= '0;
      instr     <= '0;
      pcounter4 <= '0;
      running   <= 1'b0;
      halted    <= 1'b0;
    end else begin
      running <= (next_state == ST_RUN);
      halted  <= (next_state == ST_HALT);
      if (advance) begin
        pcounter4 <= pc_plus4;
        if (i_jump) begin
          pc    <= i_addr2jump;
          instr <= NOP;
        end else begin
          pc    <= pc_plus4;
          instr <= mem_word;
        end
      end else if (flush) begin
        instr <= NOP;
      end
    end
  end

  assign o_instruction = instr;
  assign o_pcounter4   = pcounter4;
  assign o_pc          = pc;
  assign o_halt        = halted;
  assign o_running     = running;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

First stage of the 5-stage MIPS pipeline. It holds the program counter and a word-addressed instruction memory that the debug loader fills before execution. Each advancing cycle it drives the IF/ID register (instruction, PC+4) consumed by `instruction_decode`. It takes stall requests from hazard detection and jump/branch redirects from decode.

## Interface
Parameters:
- `NB_DATA` = 32: instruction and PC width.
- `NB_ADDR` = 8: instruction-memory word-address width (2^NB_ADDR words).
- `HALT_INSTR` = 32'hFFFF_FFFF: encoding that stops fetch.

Ports (one clock; reset is synchronous, active-high):
- `clk`  in  1: clock, all state updates on rising edge.
- `i_rst`  in  1: synchronous active-high reset.
- `i_load_we`  in  1: loader write strobe.
- `i_load_addr`  in  NB_ADDR: loader word address.
- `i_load_data`  in  NB_DATA: loader word.
- `i_start`  in  1: leave IDLE and begin fetching.
- `i_step_mode`  in  1: 1 = advance only on `i_step`.
- `i_step`  in  1: single-cycle advance pulse in step mode.
- `i_stall`  in  1: hold PC and IF/ID (load-use hazard).
- `i_jump`  in  1: redirect request from decode.
- `i_addr2jump`  in  NB_DATA: redirect target (byte address).
- `o_instruction`  out  NB_DATA: IF/ID instruction.
- `o_pcounter4`  out  NB_DATA: IF/ID PC+4.
- `o_pc`  out  NB_DATA: current fetch PC.
- `o_halt`  out  1: halt instruction has been fetched.
- `o_running`  out  1: FSM in RUN.

## Operation
- FSM states: IDLE, RUN, HALT. Reset → IDLE.
  - IDLE → RUN when `i_start`=1.
  - RUN → HALT when an advancing fetch reads `HALT_INSTR` and `i_jump`=0.
  - HALT is left only by reset.
- Loader: in IDLE, `i_load_we` writes `i_load_data` to `mem[i_load_addr]`. Writes in RUN/HALT are ignored. Memory contents are not cleared by reset.
- Fetch index = `pc[NB_ADDR+1:2]`; PC bits above wrap silently. Read is combinational.
- advance = RUN & !`i_stall` & (!`i_step_mode` | `i_step`).
- On advance without jump: IF/ID ← {mem[pc], pc+4}; pc ← pc+4.
- On advance with `i_jump`: pc ← `i_addr2jump`; IF/ID instruction ← 0 (NOP flush); `o_pcounter4` ← pc+4.
- Stall with jump in the same cycle: stall wins; the jump is ignored that cycle (decode re-asserts it next cycle).
- No advance: pc and IF/ID hold.
- HALT: the halt word itself enters IF/ID on the transition cycle so it flows down the pipe. Afterwards IF/ID ← NOP every cycle; pc frozen; `o_halt`=1.
- Fetching a halt word while `i_jump`=1 is flushed like any other word; no halt occurs.

## Timing
- Reset values: `o_instruction`=0, `o_pcounter4`=0, `o_pc`=0, `o_halt`=0, `o_running`=0, state IDLE.
- Latency: an instruction at PC p appears on `o_instruction` one cycle after the advancing edge that samples p.
- `i_jump`/`i_addr2jump` are sampled at the edge; the target instruction appears in IF/ID one advance later, giving one NOP bubble.
- A loader write is visible to fetch on the next cycle.
- `o_running`, `o_halt`: registered, updated on the same edge as the state change.
- Reset mid-RUN: all outputs return to reset values next edge; memory is preserved, so `i_start` re-runs the program from PC 0.

## Structure
- Shared package `mips_pkg`: `HALT_INSTR`, `NOP_INSTR`=0, FSM state encoding (2 bits), `NB_DATA`.
- Sub-module `instruction_memory`: synchronous write, combinational read, `NB_ADDR`-bit word address.
- PC, FSM and IF/ID register stay in `instruction_fetch`.

## Test plan
- Load 0x20010005, 0x20020003, 0xFFFFFFFF at words 0–2; start with `i_step_mode`=0 → `o_instruction` = those three words on consecutive cycles with `o_pcounter4` = 4, 8, 12. Then `o_halt`=1, followed by NOPs, with `o_pc`=12 frozen.
- Stall for 3 cycles while `o_pc`=8 → `o_pc`, `o_instruction` and `o_pcounter4` unchanged for 3 cycles, then the sequence resumes at 8.
- `i_jump`=1, `i_addr2jump`=0x40 at `o_pc`=4 → next `o_instruction`=0 and `o_pc`=0x40; the following cycle delivers mem[16].
- `i_jump` and `i_stall` asserted together → no change; release the stall with `i_jump` still high → redirect occurs.
- Step mode: `i_step` pulsed twice 5 cycles apart → exactly two advances, and `o_pc` moves 0→4→8.
- Loader write to word 0 during RUN → ignored (mem[0] unchanged after reset and restart). Reset at `o_pc`=8 → all outputs 0, IDLE, and the program reruns from word 0 after `i_start`.
